// File: rtl/shifter_left_sequencer.sv
// Multi-cycle left shifter: a request is shifted by STEP bits per cycle while
// enough distance remains, then by single bits, with a chosen pad bit filling vacated LSBs.
module shifter_left_sequencer #(
    parameter int WIDTH = 8,
    parameter int STEP = 4,
    localparam int AMOUNT_WIDTH = $clog2(WIDTH) + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [AMOUNT_WIDTH-1:0] in_amount,
    input  logic                    in_pad,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [AMOUNT_WIDTH-1:0] STEP_AMT  = AMOUNT_WIDTH'(STEP);
    localparam logic [AMOUNT_WIDTH-1:0] WIDTH_AMT = AMOUNT_WIDTH'(WIDTH);
    localparam logic [AMOUNT_WIDTH-1:0] ONE_AMT   = AMOUNT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic [AMOUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                    pad_q, pad_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            remaining_q <= '0;
            pad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            pad_q       <= pad_d;
        end
    end

    // Zero and out-of-range amounts resolve at acceptance; the rest walk through BUSY.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        pad_d       = pad_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pad_d = in_pad;
                    if (in_amount == '0) begin
                        data_d      = in_data;
                        remaining_d = '0;
                        state_d     = DONE;
                    end else if (in_amount >= WIDTH_AMT) begin
                        data_d      = {WIDTH{in_pad}};
                        remaining_d = '0;
                        state_d     = DONE;
                    end else begin
                        data_d      = in_data;
                        remaining_d = in_amount;
                        state_d     = BUSY;
                    end
                end
            end

            BUSY: begin
                if (remaining_q == '0) begin
                    state_d = DONE;
                end else begin
                    if (remaining_q >= STEP_AMT) begin
                        data_d      = {data_q[WIDTH-STEP-1:0], {STEP{pad_q}}};
                        remaining_d = remaining_q - STEP_AMT;
                    end else begin
                        data_d      = {data_q[WIDTH-2:0], pad_q};
                        remaining_d = remaining_q - ONE_AMT;
                    end
                    if (remaining_d == '0) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_shifter_left_sequencer.sv
// Directed and randomized checks of shifter_left_sequencer (WIDTH=8, STEP=4)
// against hand-computed results and a combinational shift model.
module tb_shifter_left_sequencer;

    localparam int WIDTH = 8;
    localparam int STEP = 4;
    localparam int AW = $clog2(WIDTH) + 1;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    in_amount;
    logic             in_pad;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    int checks;
    int failures;

    shifter_left_sequencer #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_amount(in_amount),
        .in_pad(in_pad),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Plain combinational reference: shift with pad fill, all pad when out of range.
    function automatic logic [WIDTH-1:0] shift_model(input logic [WIDTH-1:0] d,
                                                     input int amt, input logic p);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < amt) r[i] = p;
            else         r[i] = d[i-amt];
        end
        return r;
    endfunction

    task automatic step_cycle();
        @(posedge clock);
        #1;
    endtask

    // Presents one request from IDLE, then counts edges until out_valid rises.
    task automatic run_request(input logic [WIDTH-1:0] d, input int amt, input logic p,
                               input logic [WIDTH-1:0] exp_data, input int exp_k, input string name);
        int cnt;
        in_data   = d;
        in_amount = AW'(amt);
        in_pad    = p;
        in_valid  = 1'b1;
        step_cycle();
        in_valid  = 1'b0;
        in_data   = ~d;
        in_amount = '0;
        in_pad    = ~p;
        if (exp_k > 0) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s busy_after_accept: busy=%b in_ready=%b required busy=1 in_ready=0",
                         name, busy, in_ready);
            end
        end
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 50) begin
            step_cycle();
            cnt++;
        end
        checks++;
        if (cnt !== exp_k) begin
            failures++;
            $display("[TB] FAIL %s latency: got k=%0d required k=%0d", name, cnt, exp_k);
        end
        checks++;
        if (out_data !== exp_data) begin
            failures++;
            $display("[TB] FAIL %s data: got %h required %h", name, out_data, exp_data);
        end
        out_ready = 1'b1;
        step_cycle();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s release: in_ready=%b out_valid=%b required 1/0",
                     name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step_cycle();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%h required 1/0/0/00",
                     in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic test_shift_cases();
        run_request(8'hB5, 5, 1'b0, 8'hA0, 2, "b5_amt5_pad0");
        run_request(8'hB5, 5, 1'b1, 8'hBF, 2, "b5_amt5_pad1");
        run_request(8'hB5, 3, 1'b0, 8'hA8, 3, "b5_amt3");
        run_request(8'hB5, 4, 1'b0, 8'h50, 1, "b5_amt4");
        run_request(8'h3C, 2, 1'b1, 8'hF3, 2, "3c_amt2_pad1");
        run_request(8'hFF, 6, 1'b0, 8'hC0, 3, "ff_amt6");
        run_request(8'h81, 7, 1'b1, 8'hFF, 4, "81_amt7_pad1");
    endtask

    task automatic test_zero_and_overflow();
        run_request(8'hB5, 0, 1'b1, 8'hB5, 0, "amt0");
        run_request(8'hB5, 8, 1'b1, 8'hFF, 0, "amt8_pad1");
        run_request(8'hB5, 15, 1'b0, 8'h00, 0, "amt15_pad0");
    endtask

    task automatic test_backpressure();
        int bad;
        int cnt;
        in_data   = 8'hB5;
        in_amount = AW'(5);
        in_pad    = 1'b0;
        in_valid  = 1'b1;
        step_cycle();
        in_valid = 1'b0;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 50) begin
            step_cycle();
            cnt++;
        end
        checks++;
        if (cnt !== 2) begin
            failures++;
            $display("[TB] FAIL hold_latency: got k=%0d required k=2", cnt);
        end
        in_valid  = 1'b1;
        in_data   = 8'h0F;
        in_amount = AW'(1);
        in_pad    = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step_cycle();
            if (out_valid !== 1'b1 || out_data !== 8'hA0 || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL hold_stable: %0d unstable cycles, out_valid=%b out_data=%h in_ready=%b required 1/a0/0",
                     bad, out_valid, out_data, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step_cycle();
        out_ready = 1'b0;
        step_cycle();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'hA0) begin
            failures++;
            $display("[TB] FAIL hold_no_accept: in_ready=%b out_valid=%b out_data=%h required 1/0/a0",
                     in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        in_data   = 8'hB5;
        in_amount = AW'(7);
        in_pad    = 1'b1;
        in_valid  = 1'b1;
        step_cycle();
        in_valid = 1'b0;
        step_cycle();
        reset     = 1'b1;
        out_ready = 1'b1;
        step_cycle();
        reset     = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_state: in_ready=%b out_valid=%b out_data=%h busy=%b required 1/0/00/0",
                     in_ready, out_valid, out_data, busy);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step_cycle();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("[TB] FAIL abort_no_result: out_valid high %0d cycles required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] exp;
        int sent;
        int received;
        int errors;
        int timeout;
        int n;
        n = 48;
        sent = 0;
        received = 0;
        errors = 0;
        timeout = 0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    int amt;
                    int wait_cnt;
                    amt       = (i < 16) ? i : int'($urandom_range(0, 15));
                    in_data   = WIDTH'($urandom);
                    in_pad    = 1'($urandom);
                    in_amount = AW'(amt);
                    in_valid  = 1'b1;
                    wait_cnt  = 0;
                    while (in_ready !== 1'b1 && wait_cnt < 200) begin
                        step_cycle();
                        wait_cnt++;
                    end
                    if (wait_cnt >= 200) begin
                        timeout++;
                        break;
                    end
                    exp_q.push_back(shift_model(in_data, amt, in_pad));
                    sent++;
                    step_cycle();
                    in_valid = 1'($urandom_range(0, 1));
                    in_data  = WIDTH'($urandom);
                    in_valid = 1'b0;
                end
                in_valid = 1'b0;
            end
            begin
                int cyc;
                cyc = 0;
                while ((received < n) && cyc < 4000 && timeout == 0) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid === 1'b1 && out_ready === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL b2b_duplicate: result %h with nothing outstanding", out_data);
                        end else begin
                            exp = exp_q.pop_front();
                            if (out_data !== exp) begin
                                errors++;
                                $display("[TB] FAIL b2b_data: got %h required %h", out_data, exp);
                            end
                        end
                        received++;
                    end
                    step_cycle();
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        checks++;
        if (errors != 0) begin
            failures++;
            $display("[TB] FAIL b2b_results: %0d bad results required 0", errors);
        end
        checks++;
        if (timeout != 0 || sent != n || received != n || exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL b2b_count: sent=%0d received=%0d outstanding=%0d required %0d/%0d/0",
                     sent, received, exp_q.size(), n, n);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amount = '0;
        in_pad    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_shift_cases();
        test_zero_and_overflow();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
